// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flow-control encodings and default address width.
package cpu_pkg;

   localparam int unsigned CPU_AW = 8;

   // Flow-control codes as emitted by the decoder; 8..15 decode as "none".
   typedef enum logic [3:0] {
      CT_NONE = 4'd0,
      CT_RET  = 4'd1,
      CT_JUMP = 4'd2,
      CT_CALL = 4'd3,
      CT_JZ   = 4'd4,
      CT_JNZ  = 4'd5,
      CT_JC   = 4'd6,
      CT_JNC  = 4'd7
   } ct_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Decoder/evaluator-to-sequencer bus: flow-control request in, PC and status out.
interface pc_seq_ctrl_if #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
);
   logic                       en;
   logic [3:0]                 contl;
   logic                       tcnd;
   logic [AW-1:0]              target;
   logic [AW-1:0]              pc;
   logic                       flush;
   logic [$clog2(DEPTH):0]     sp;
   logic                       stk_ovf;
   logic                       stk_unf;

   modport master (
      output en, contl, tcnd, target,
      input  pc, flush, sp, stk_ovf, stk_unf
   );

   modport slave (
      input  en, contl, tcnd, target,
      output pc, flush, sp, stk_ovf, stk_unf
   );
endinterface

// File: rtl/pc_seq_ctrl_ret_stack.sv
// Return-address LIFO. Push is ignored when full and pop when empty;
// overflow/underflow policy lives in the caller.
module ret_stack #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [AW-1:0]          i_data,
   output logic [AW-1:0]          o_top,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   logic [AW-1:0] r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_rd_idx;

   // DEPTH is a power of two, so the low count bits wrap to the right slot.
   assign w_wr_idx = r_count[IW-1:0];
   assign w_rd_idx = r_count[IW-1:0] - IW'(1);
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_top    = r_mem[w_rd_idx];
   assign o_count  = r_count;

   // Occupancy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_push && !o_full) begin
         r_count <= r_count + CW'(1);
      end else if (i_pop && !o_empty) begin
         r_count <= r_count - CW'(1);
      end
   end

   // Storage; contents are don't-care after reset so only the write is gated.
   always_ff @(posedge clk) begin
      if (!rst && i_push && !o_full) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end
endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: next-PC select, return stack control, flush and
// sticky stack-error flags. All outputs are registered.
module pc_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned AW    = CPU_AW,
   parameter int unsigned DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   pc_seq_ctrl_if.slave  bus
);
   logic [AW-1:0]          r_pc;
   logic                   r_flush;
   logic                   r_ovf;
   logic                   r_unf;
   logic [AW-1:0]          w_pc_d;
   logic [AW-1:0]          w_pc_inc;
   logic                   w_flush_d;
   logic                   w_ovf_d;
   logic                   w_unf_d;
   logic                   w_push;
   logic                   w_pop;
   logic [AW-1:0]          w_top;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_full;
   logic                   w_empty;

   assign w_pc_inc = r_pc + AW'(1);

   ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_inc),
      .o_top   (w_top),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-PC select and stack/flag control for the retiring instruction.
   always_comb begin
      w_pc_d    = r_pc;
      w_flush_d = 1'b0;
      w_ovf_d   = r_ovf;
      w_unf_d   = r_unf;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      if (bus.en) begin
         w_pc_d = w_pc_inc;
         if (bus.tcnd) begin
            case (bus.contl)
               CT_RET: begin
                  if (!w_empty) begin
                     w_pc_d    = w_top;
                     w_pop     = 1'b1;
                     w_flush_d = 1'b1;
                  end else begin
                     // Empty-stack RET falls through and does not flush.
                     w_unf_d = 1'b1;
                  end
               end
               CT_CALL: begin
                  w_pc_d    = bus.target;
                  w_flush_d = 1'b1;
                  if (w_full) w_ovf_d = 1'b1;
                  else        w_push  = 1'b1;
               end
               CT_JUMP, CT_JZ, CT_JNZ, CT_JC, CT_JNC: begin
                  w_pc_d    = bus.target;
                  w_flush_d = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // PC, flush and sticky flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= '0;
         r_flush <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_pc    <= w_pc_d;
         r_flush <= w_flush_d;
         r_ovf   <= w_ovf_d;
         r_unf   <= w_unf_d;
      end
   end

   assign bus.pc      = r_pc;
   assign bus.flush   = r_flush;
   assign bus.sp      = w_count;
   assign bus.stk_ovf = r_ovf;
   assign bus.stk_unf = r_unf;
endmodule
